switch_led_mode_ctrl: RTL and testbench

//  Sequences the board LED output stage from a single push-button.
//  - Synchronises and debounces i_Switch_1.
//  - Each debounced release advances a 4-state mode FSM: OFF -> ALL_ON -> BLINK -> CHASE -> OFF.
//  - A shared tick timer drives the LED patterns.
//  - Sits between the switch pad and the o_LED pins; replaces the raw release-toggle path.

---
 rtl/switch_led_mode_ctrl.sv | 121 ++++++++++++
 tb/tb_switch_led_mode_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/switch_led_mode_ctrl.sv
// Push-button mode sequencer: sync + debounce, release advances OFF/ALL_ON/BLINK/CHASE LED patterns.
// Latency: input edge to debounced level DEBOUNCE_LIMIT+2 cycles; mode/LED update one edge after release.
// Backpressure: none; free-running, outputs registered.
module switch_led_mode_ctrl #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int BLINK_LIMIT    = 6250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch_1,
    output logic [3:0] o_LED,
    output logic [1:0] o_Mode
);

    localparam int DB_W = $clog2(DEBOUNCE_LIMIT);
    localparam int TK_W = $clog2(BLINK_LIMIT);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [TK_W-1:0] TK_MAX = TK_W'(BLINK_LIMIT - 1);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_ALL_ON = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_CHASE  = 2'd3
    } mode_t;

    logic            sw_s1;
    logic            sw_s2;
    logic            stable;
    logic            stable_d;
    logic [DB_W-1:0] db_cnt;
    logic            release_pls;

    mode_t           mode_q;
    mode_t           mode_d;
    logic [3:0]      led_q;
    logic [3:0]      led_d;
    logic [TK_W-1:0] tick_cnt;
    logic [TK_W-1:0] tick_cnt_d;
    logic            tick;

    // Synchroniser and debounce: a new level is accepted only after it persists.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sw_s1    <= 1'b0;
            sw_s2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sw_s1    <= i_Switch_1;
            sw_s2    <= sw_s1;
            stable_d <= stable;
            if (sw_s2 != stable) begin
                if (db_cnt == DB_MAX) begin
                    stable <= sw_s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign release_pls = stable_d & ~stable;
    assign tick = ((mode_q == MODE_BLINK) || (mode_q == MODE_CHASE)) && (tick_cnt == TK_MAX);

    always_comb begin
        mode_d     = mode_q;
        led_d      = led_q;
        tick_cnt_d = tick_cnt;

        // A release takes priority over a coincident tick; the new mode starts from its entry pattern.
        if (release_pls) begin
            tick_cnt_d = '0;
            case (mode_q)
                MODE_OFF:    mode_d = MODE_ALL_ON;
                MODE_ALL_ON: mode_d = MODE_BLINK;
                MODE_BLINK:  mode_d = MODE_CHASE;
                default:     mode_d = MODE_OFF;
            endcase
            case (mode_d)
                MODE_OFF:    led_d = 4'b0000;
                MODE_ALL_ON: led_d = 4'b1111;
                MODE_BLINK:  led_d = 4'b1111;
                default:     led_d = 4'b0001;
            endcase
        end else begin
            if ((mode_q == MODE_OFF) || (mode_q == MODE_ALL_ON) || tick) begin
                tick_cnt_d = '0;
            end else begin
                tick_cnt_d = tick_cnt + 1'b1;
            end
            if (tick) begin
                if (mode_q == MODE_BLINK) begin
                    led_d = ~led_q;
                end else begin
                    led_d = {led_q[2:0], led_q[3]};
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            mode_q   <= MODE_OFF;
            led_q    <= 4'b0000;
            tick_cnt <= '0;
        end else begin
            mode_q   <= mode_d;
            led_q    <= led_d;
            tick_cnt <= tick_cnt_d;
        end
    end

    assign o_Mode = mode_q;
    assign o_LED  = led_q;

endmodule

// File: tb/tb_switch_led_mode_ctrl.sv
// Bench for switch_led_mode_ctrl: directed button sequences then random switch activity,
// compared every cycle against a mode/elapsed-time model of the LED patterns.
module tb_switch_led_mode_ctrl;

    localparam int DL = 4;
    localparam int BL = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw;
    logic [3:0] led;
    logic [1:0] mode;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    switch_led_mode_ctrl #(
        .DEBOUNCE_LIMIT(DL),
        .BLINK_LIMIT   (BL)
    ) dut (
        .i_Clk     (clk),
        .i_Rst     (rst),
        .i_Switch_1(sw),
        .o_LED     (led),
        .o_Mode    (mode)
    );

    // Reference model: mode number plus cycles elapsed since entering it.
    bit m_s1, m_s2, m_stable, m_pend;
    int m_run, m_mode, m_elapsed;

    function automatic logic [3:0] exp_led();
        int ticks;
        ticks = m_elapsed / BL;
        case (m_mode)
            0:       return 4'b0000;
            1:       return 4'b1111;
            2:       return (ticks % 2 == 0) ? 4'b1111 : 4'b0000;
            default: return 4'(1 << (ticks % 4));
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit in);
        bit old_stable;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_stable = 0; m_pend = 0;
            m_run = 0; m_mode = 0; m_elapsed = 0;
        end else begin
            if (m_pend) begin
                m_mode    = (m_mode + 1) % 4;
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
            old_stable = m_stable;
            // A level is adopted once it has differed from the accepted one for DL consecutive cycles.
            if (m_s2 != m_stable) begin
                m_run++;
                if (m_run == DL) begin
                    m_stable = m_s2;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2   = m_s1;
            m_s1   = in;
            m_pend = old_stable && !m_stable;
        end
    endtask

    task automatic check_model();
        checks++;
        assert (mode === 2'(m_mode)) else begin
            failures++;
            $error("FAIL mode observed=%0d expected=%0d t=%0t", mode, m_mode, $time);
        end
        checks++;
        assert (led === exp_led()) else begin
            failures++;
            $error("FAIL led observed=%b expected=%b mode=%0d t=%0t", led, exp_led(), m_mode, $time);
        end
    endtask

    task automatic check_fixed(input string tag, input logic [1:0] em, input logic [3:0] el);
        checks++;
        assert (mode === em && led === el) else begin
            failures++;
            $error("FAIL %s observed mode=%0d led=%b expected mode=%0d led=%b", tag, mode, led, em, el);
        end
    endtask

    task automatic cycle(input bit r, input bit in);
        rst = r;
        sw  = in;
        @(posedge clk);
        model_edge(r, in);
        @(negedge clk);
        check_model();
    endtask

    task automatic run(input int n, input bit r, input bit in);
        for (int i = 0; i < n; i++) cycle(r, in);
    endtask

    task automatic press_release();
        run(20, 0, 1);
        run(20, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        sw  = 1'b0;

        run(2, 1, 0);
        check_fixed("reset", 2'd0, 4'b0000);
        run(50, 0, 0);
        check_fixed("idle_after_reset", 2'd0, 4'b0000);

        run(3, 0, 1);
        run(20, 0, 0);
        check_fixed("glitch_reject", 2'd0, 4'b0000);

        run(20, 0, 1);
        check_fixed("press_no_change", 2'd0, 4'b0000);
        run(DL + 4, 0, 0);
        check_fixed("first_release", 2'd1, 4'b1111);
        run(12, 0, 0);

        run(20, 0, 1);
        run(DL + 4, 0, 0);
        check_fixed("blink_entry", 2'd2, 4'b1111);
        run(40, 0, 0);

        press_release();
        run(40, 0, 0);
        check_fixed("chase_mode", 2'd3, exp_led());
        press_release();
        check_fixed("wrap_to_off", 2'd0, 4'b0000);

        // Reset with the switch held high while chasing.
        press_release();
        press_release();
        press_release();
        run(11, 0, 0);
        run(5, 0, 1);
        cycle(1, 1);
        check_fixed("reset_mid_chase", 2'd0, 4'b0000);
        run(20, 0, 1);
        run(20, 0, 0);
        check_fixed("release_after_reset", 2'd1, 4'b1111);

        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 39) == 0) cycle(1, 1'($urandom_range(0, 1)));
            run($urandom_range(1, 25), 0, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
